// File: rtl/rv32i_spi_display_master.sv
// -----------------------------------------------------------------------------
// rv32i_spi_display_master
//
// SPI master for the display peripheral. It sits behind the MMU's display
// registers. The MMU offers one 8- or 16-bit word per transaction over a
// valid/ready handshake. The word is shifted out MSB first in SPI mode 0
// (CPOL=0, CPHA=0). MISO is captured into a receive word, which is returned
// with a one-cycle valid pulse.
//
// Transfer sequence:
//   SETUP (CLK_DIV cycles)
//   SHIFT (2*N*CLK_DIV cycles)
//   HOLD  (CLK_DIV cycles, chip deselected)
//   DONE  (1 cycle)
//
// Parameters:
//   CLK_DIV        spi_clk half-period in clk cycles (>= 1)
//
// Ports:
//   clk            system clock (sysclk domain)
//   rst_n          asynchronous active-low reset
//   i_valid        MMU offers a transaction
//   o_ready        idle and able to accept
//   i_tx_data      word to send ([7:0] only in 8-bit mode)
//   i_wide         1 = 16-bit transfer, 0 = 8-bit transfer
//   i_dc           data/command flag for this transfer
//   o_rx_data      captured MISO word (upper byte zero in 8-bit mode)
//   o_rx_valid     one-cycle pulse when o_rx_data is updated
//   spi_clk        SPI clock
//   spi_mosi       serial data out, MSB first
//   spi_miso       serial data in
//   display_csb    chip select, active low
//   data_commandb  1 = data, 0 = command
//
// Build option:
//   SPI_LOOPBACK_EN  When defined, the receive sampler takes the internal MOSI
//                    register instead of the spi_miso pin.
// -----------------------------------------------------------------------------
module rv32i_spi_display_master #(
  parameter int CLK_DIV = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_valid,
  output logic        o_ready,
  input  logic [15:0] i_tx_data,
  input  logic        i_wide,
  input  logic        i_dc,
  output logic [15:0] o_rx_data,
  output logic        o_rx_valid,
  output logic        spi_clk,
  output logic        spi_mosi,
  input  logic        spi_miso,
  output logic        display_csb,
  output logic        data_commandb
);

  localparam int              CNT_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_SHIFT = 3'd2,
    ST_HOLD  = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  state_t           state_r,    state_s;
  logic [CNT_W-1:0] cnt_r,      cnt_s;
  logic [3:0]       bit_r,      bit_s;
  logic [15:0]      tx_sh_r,    tx_sh_s;
  logic [15:0]      rx_sh_r,    rx_sh_s;
  logic             wide_r,     wide_s;
  logic             ready_r,    ready_s;
  logic             rx_valid_r, rx_valid_s;
  logic [15:0]      rx_data_r,  rx_data_s;
  logic             sclk_r,     sclk_s;
  logic             mosi_r,     mosi_s;
  logic             csb_r,      csb_s;
  logic             dc_r,       dc_s;
  logic             accept_s;
  logic             sample_bit_s;

`ifdef SPI_LOOPBACK_EN
  // The internal MOSI register holds the current bit at the rising spi_clk
  // edge, so the receive word reproduces the transmitted word.
  logic unused_miso_s;
  assign unused_miso_s = spi_miso;
  assign sample_bit_s  = mosi_r;
`else
  assign sample_bit_s  = spi_miso;
`endif

  // Next-state and next-output logic for the transfer sequencer.
  always_comb begin
    state_s    = state_r;
    cnt_s      = cnt_r;
    bit_s      = bit_r;
    tx_sh_s    = tx_sh_r;
    rx_sh_s    = rx_sh_r;
    wide_s     = wide_r;
    ready_s    = ready_r;
    rx_valid_s = 1'b0;
    rx_data_s  = rx_data_r;
    sclk_s     = sclk_r;
    mosi_s     = mosi_r;
    csb_s      = csb_r;
    dc_s       = dc_r;
    accept_s   = i_valid & ready_r;

    case (state_r)
      // DONE accepts like IDLE so that transfers can run back to back.
      ST_IDLE, ST_DONE: begin
        if (accept_s) begin
          state_s = ST_SETUP;
          cnt_s   = CNT_LOAD;
          ready_s = 1'b0;
          csb_s   = 1'b0;
          sclk_s  = 1'b0;
          dc_s    = i_dc;
          wide_s  = i_wide;
          rx_sh_s = 16'h0000;
          // The transmit word is MSB-aligned so bit 15 is always next out.
          if (i_wide) begin
            tx_sh_s = i_tx_data;
            mosi_s  = i_tx_data[15];
            bit_s   = 4'd15;
          end else begin
            tx_sh_s = {i_tx_data[7:0], 8'h00};
            mosi_s  = i_tx_data[7];
            bit_s   = 4'd7;
          end
        end else begin
          state_s = ST_IDLE;
          ready_s = 1'b1;
        end
      end

      ST_SETUP: begin
        if (cnt_r == CNT_ZERO) begin
          state_s = ST_SHIFT;
          cnt_s   = CNT_LOAD;
        end else begin
          cnt_s   = cnt_r - CNT_ONE;
        end
      end

      ST_SHIFT: begin
        if (cnt_r != CNT_ZERO) begin
          cnt_s = cnt_r - CNT_ONE;
        end else begin
          cnt_s = CNT_LOAD;
          if (!sclk_r) begin
            // Rising spi_clk: capture MISO into the LSB.
            sclk_s  = 1'b1;
            rx_sh_s = {rx_sh_r[14:0], sample_bit_s};
          end else begin
            // Falling spi_clk: present the next bit, or finish.
            sclk_s = 1'b0;
            if (bit_r == 4'd0) begin
              state_s = ST_HOLD;
              mosi_s  = 1'b0;
              csb_s   = 1'b1;
            end else begin
              bit_s   = bit_r - 4'd1;
              tx_sh_s = {tx_sh_r[14:0], 1'b0};
              mosi_s  = tx_sh_r[14];
            end
          end
        end
      end

      ST_HOLD: begin
        if (cnt_r == CNT_ZERO) begin
          state_s    = ST_DONE;
          rx_valid_s = 1'b1;
          ready_s    = 1'b1;
          rx_data_s  = wide_r ? rx_sh_r : {8'h00, rx_sh_r[7:0]};
        end else begin
          cnt_s      = cnt_r - CNT_ONE;
        end
      end

      default: begin
        state_s = ST_IDLE;
        ready_s = 1'b1;
        csb_s   = 1'b1;
        sclk_s  = 1'b0;
        mosi_s  = 1'b0;
      end
    endcase
  end

  // State and output registers; reset aborts any transfer in progress.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= ST_IDLE;
      cnt_r      <= CNT_ZERO;
      bit_r      <= 4'd0;
      tx_sh_r    <= 16'h0000;
      rx_sh_r    <= 16'h0000;
      wide_r     <= 1'b0;
      ready_r    <= 1'b1;
      rx_valid_r <= 1'b0;
      rx_data_r  <= 16'h0000;
      sclk_r     <= 1'b0;
      mosi_r     <= 1'b0;
      csb_r      <= 1'b1;
      dc_r       <= 1'b1;
    end else begin
      state_r    <= state_s;
      cnt_r      <= cnt_s;
      bit_r      <= bit_s;
      tx_sh_r    <= tx_sh_s;
      rx_sh_r    <= rx_sh_s;
      wide_r     <= wide_s;
      ready_r    <= ready_s;
      rx_valid_r <= rx_valid_s;
      rx_data_r  <= rx_data_s;
      sclk_r     <= sclk_s;
      mosi_r     <= mosi_s;
      csb_r      <= csb_s;
      dc_r       <= dc_s;
    end
  end

  assign o_ready       = ready_r;
  assign o_rx_valid    = rx_valid_r;
  assign o_rx_data     = rx_data_r;
  assign spi_clk       = sclk_r;
  assign spi_mosi      = mosi_r;
  assign display_csb   = csb_r;
  assign data_commandb = dc_r;

endmodule

// File: tb/tb_rv32i_spi_display_master.sv
// -----------------------------------------------------------------------------
// tb_rv32i_spi_display_master
//
// Self-checking bench for rv32i_spi_display_master (CLK_DIV=4).
//
// A cycle-indexed reference model computes every output from the transfer
// timing formulas:
//   csb low     in cycles 1..(2N+1)*D
//   DONE        in cycle  (2N+2)*D+1
// The model is compared against the DUT on every falling clk edge. Literal
// expectations pin the key numbers:
//   - MOSI bit pattern
//   - rx_valid cycle
//   - csb-low length
//   - received words
//   - deselect gap
//   - reset-abort behaviour
// -----------------------------------------------------------------------------
module tb_rv32i_spi_display_master;

  localparam int D = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_valid;
  logic        o_ready;
  logic [15:0] i_tx_data;
  logic        i_wide;
  logic        i_dc;
  logic [15:0] o_rx_data;
  logic        o_rx_valid;
  logic        spi_clk;
  logic        spi_mosi;
  logic        spi_miso;
  logic        display_csb;
  logic        data_commandb;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  rv32i_spi_display_master #(.CLK_DIV(D)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_valid       (i_valid),
    .o_ready       (o_ready),
    .i_tx_data     (i_tx_data),
    .i_wide        (i_wide),
    .i_dc          (i_dc),
    .o_rx_data     (o_rx_data),
    .o_rx_valid    (o_rx_valid),
    .spi_clk       (spi_clk),
    .spi_mosi      (spi_mosi),
    .spi_miso      (spi_miso),
    .display_csb   (display_csb),
    .data_commandb (data_commandb)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- slave model: shifts slave_word out, changing on falling spi_clk
  logic [15:0] slave_word;
  int          slave_n;
  int          sbit;
`ifndef SPI_LOOPBACK_EN
  always @(negedge display_csb) begin
    sbit     = slave_n - 1;
    spi_miso = slave_word[sbit];
  end
  always @(negedge spi_clk) begin
    if (display_csb === 1'b0 && sbit > 0) begin
      sbit     = sbit - 1;
      spi_miso = slave_word[sbit];
    end
  end
`endif

  // ---------------- monitors
  logic [15:0] mosi_cap = 16'h0000;
  int          csb_low_cnt  = 0;
  int          xfers        = 0;
  int          last_low_cyc = 0;
  int          last_gap     = -1;
  logic        have_low     = 1'b0;
  logic        prev_csb     = 1'b1;

  always @(posedge spi_clk) mosi_cap = {mosi_cap[14:0], spi_mosi};
  always @(negedge display_csb) xfers++;
  always @(negedge clk) begin
    if (display_csb === 1'b0) begin
      csb_low_cnt++;
      if (prev_csb === 1'b1 && have_low) last_gap = cyc - last_low_cyc - 1;
      last_low_cyc = cyc;
      have_low     = 1'b1;
    end
    prev_csb = display_csb;
  end

  // ---------------- reference model and per-cycle compare
  logic        m_active = 1'b0;
  int          m_k      = 0;
  int          m_n      = 8;
  logic [15:0] m_word   = 16'h0000;
  logic [15:0] m_rxword = 16'h0000;
  logic [15:0] m_rx     = 16'h0000;
  logic        m_dc     = 1'b1;
  logic        acc_pend = 1'b0;
  int          p_n      = 8;
  logic [15:0] p_word   = 16'h0000;
  logic [15:0] p_rxword = 16'h0000;
  logic        p_dc     = 1'b1;
  int          rxv_cyc  = 0;
  int          rxv_count = 0;

  always @(negedge clk) begin : compare
    int          e_end;
    int          t_end;
    int          j;
    logic        e_csb;
    logic        e_sclk;
    logic        e_mosi;
    logic        e_ready;
    logic        e_rxv;
    logic [15:0] mask;

    if (!rst_n) begin
      m_active = 1'b0;
      m_rx     = 16'h0000;
      m_dc     = 1'b1;
    end else if (acc_pend) begin
      m_active = 1'b1;
      m_k      = 1;
      m_n      = p_n;
      m_word   = p_word;
      m_rxword = p_rxword;
      m_dc     = p_dc;
    end else if (m_active) begin
      m_k = m_k + 1;
      if (m_k > (2 * m_n + 2) * D + 1) m_active = 1'b0;
    end

    e_csb   = 1'b1;
    e_sclk  = 1'b0;
    e_mosi  = 1'b0;
    e_ready = 1'b1;
    e_rxv   = 1'b0;
    if (m_active) begin
      e_end   = (2 * m_n + 1) * D;
      t_end   = e_end + D + 1;
      e_ready = (m_k == t_end);
      e_rxv   = (m_k == t_end);
      if (m_k <= e_end) e_csb = 1'b0;
      if (m_k <= D) begin
        e_mosi = m_word[m_n - 1];
      end else if (m_k <= e_end) begin
        j      = m_k - D - 1;
        e_sclk = ((j / D) % 2) == 1;
        e_mosi = m_word[m_n - 1 - j / (2 * D)];
      end
      if (m_k == t_end) m_rx = m_rxword;
    end

    chk("csb",      {31'd0, display_csb},   {31'd0, e_csb});
    chk("spi_clk",  {31'd0, spi_clk},       {31'd0, e_sclk});
    chk("mosi",     {31'd0, spi_mosi},      {31'd0, e_mosi});
    chk("ready",    {31'd0, o_ready},       {31'd0, e_ready});
    chk("rx_valid", {31'd0, o_rx_valid},    {31'd0, e_rxv});
    chk("rx_data",  {16'd0, o_rx_data},     {16'd0, m_rx});
    chk("dc",       {31'd0, data_commandb}, {31'd0, m_dc});

    if (o_rx_valid === 1'b1) begin
      rxv_cyc   = cyc;
      rxv_count = rxv_count + 1;
    end

    // Inputs seen now are what the next rising edge samples.
    acc_pend = rst_n && i_valid && e_ready;
    p_n      = i_wide ? 16 : 8;
    p_word   = i_tx_data;
    p_dc     = i_dc;
    mask     = i_wide ? 16'hFFFF : 16'h00FF;
`ifdef SPI_LOOPBACK_EN
    p_rxword = i_tx_data & mask;
`else
    p_rxword = slave_word & mask;
`endif
  end

  // ---------------- driver helpers (called just after a rising edge)
  task automatic wait_edges(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic launch(input logic [15:0] w, input logic wide, input logic dc, output int c0);
    i_tx_data = w;
    i_wide    = wide;
    i_dc      = dc;
    i_valid   = 1'b1;
    @(posedge clk);
    #1;
    i_valid = 1'b0;
    c0      = cyc;
  endtask

  // ---------------- directed stimulus
  initial begin
    int c0;
    int c1;
    int lo0;
    int x0;
    int rv0;

    rst_n      = 1'b1;
    i_valid    = 1'b0;
    i_tx_data  = 16'h0000;
    i_wide     = 1'b0;
    i_dc       = 1'b0;
    spi_miso   = 1'b0;
    slave_word = 16'h0000;
    slave_n    = 8;
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready",    {31'd0, o_ready},       32'd1);
    chk("rst_csb",      {31'd0, display_csb},   32'd1);
    chk("rst_sclk",     {31'd0, spi_clk},       32'd0);
    chk("rst_dc",       {31'd0, data_commandb}, 32'd1);
    chk("rst_rx_valid", {31'd0, o_rx_valid},    32'd0);
    chk("rst_mosi",     {31'd0, spi_mosi},      32'd0);
    chk("rst_rx_data",  {16'd0, o_rx_data},     32'd0);
    rst_n = 1'b1;
    wait_edges(2);

    // 8-bit command write of 0xA5; slave answers 0x5A.
    slave_word = 16'h005A;
    slave_n    = 8;
    lo0        = csb_low_cnt;
    launch(16'h00A5, 1'b0, 1'b0, c0);
    wait_edges(75);
    chk("w8_mosi_bits", {24'd0, mosi_cap[7:0]}, 32'h000000A5);
    chk("w8_rxv_cycle", rxv_cyc - c0 + 1,       32'd73);
    chk("w8_csb_low",   csb_low_cnt - lo0,      32'd68);
`ifdef SPI_LOOPBACK_EN
    chk("w8_rx_data",   {16'd0, o_rx_data},     32'h000000A5);
`else
    chk("w8_rx_data",   {16'd0, o_rx_data},     32'h0000005A);
`endif

    // 16-bit read; slave returns 0xBEEF.
    slave_word = 16'hBEEF;
    slave_n    = 16;
    launch(16'h1234, 1'b1, 1'b1, c0);
    wait_edges(139);
    chk("r16_rxv_cycle", rxv_cyc - c0 + 1,   32'd137);
`ifdef SPI_LOOPBACK_EN
    chk("r16_rx_data",   {16'd0, o_rx_data}, 32'h00001234);
`else
    chk("r16_rx_data",   {16'd0, o_rx_data}, 32'h0000BEEF);
`endif

    // Busy pulse is ignored; a request in the DONE cycle (cycle 73) is taken.
    slave_word = 16'h0096;
    slave_n    = 8;
    x0         = xfers;
    launch(16'h00C3, 1'b0, 1'b1, c0);
    wait_edges(19);
    i_tx_data = 16'h0012;
    i_valid   = 1'b1;
    wait_edges(1);
    i_valid = 1'b0;
    wait_edges(52);
    launch(16'h0034, 1'b0, 1'b0, c1);
    chk("b2b_accept_cycle", c1 - c0 + 1, 32'd74);
    wait_edges(75);
    chk("b2b_xfers", xfers - x0, 32'd2);
    // Deselect between transfers: HOLD (D cycles) plus the DONE cycle.
    chk("b2b_gap",   last_gap,   D + 1);

    // Reset part-way into a 16-bit transfer, after three full bits.
    slave_word = 16'h0F0F;
    slave_n    = 16;
    rv0        = rxv_count;
    launch(16'h00FF, 1'b1, 1'b1, c0);
    wait_edges(29);
    rst_n = 1'b0;
    #1;
    chk("abort_csb",   {31'd0, display_csb}, 32'd1);
    chk("abort_sclk",  {31'd0, spi_clk},     32'd0);
    chk("abort_ready", {31'd0, o_ready},     32'd1);
    wait_edges(3);
    rst_n = 1'b1;
    wait_edges(1);
    chk("abort_ready_after", {31'd0, o_ready}, 32'd1);
    wait_edges(140);
    chk("abort_no_rxv", rxv_count - rv0, 32'd0);

`ifdef SPI_LOOPBACK_EN
    // Loopback: spi_miso stays 0, received word equals sent word.
    spi_miso = 1'b0;
    launch(16'h003C, 1'b0, 1'b1, c0);
    wait_edges(75);
    chk("loop_rx_data", {16'd0, o_rx_data}, 32'h0000003C);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
